// File: rtl/trie_table_writer.sv
// Builds the Aho-Corasick goto table from a stream of keyword bytes, two nibble
// lookups per byte, allocating fresh states on misses and flagging keyword ends.
module trie_table_writer #(
  parameter int STATE_W = 8,
  parameter int SYM_W   = 4,
  parameter int ADDR_W  = 12
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLEAR,
  input  logic                 KEY_VALID,
  output logic                 KEY_READY,
  input  logic [2*SYM_W-1:0]   KEY_DATA,
  input  logic                 KEY_LAST,
  output logic [ADDR_W-1:0]    G_RADDR,
  input  logic [STATE_W-1:0]   G_RDATA,
  output logic                 G_WE,
  output logic [ADDR_W-1:0]    G_WADDR,
  output logic [STATE_W-1:0]   G_WDATA,
  output logic                 M_WE,
  output logic [STATE_W-1:0]   M_WADDR,
  output logic                 M_WDATA,
  output logic                 BUSY,
  output logic                 OVERFLOW,
  output logic [STATE_W:0]     NUM_STATES
);

  typedef enum logic [2:0] {
    IDLE, LOOK_HI, EVAL_HI, LOOK_LO, EVAL_LO, MARK, CLR, ERR
  } state_t;

  state_t               r_state, w_nextState;
  logic [2*SYM_W-1:0]   r_byte;
  logic                 r_last;
  logic [STATE_W-1:0]   r_cur;
  logic [STATE_W:0]     r_nextFree;
  logic                 r_overflow;
  logic [ADDR_W-1:0]    r_clrCnt;

  logic [SYM_W-1:0]     w_nibble;
  logic                 w_isEval, w_miss, w_full;
  logic                 w_alloc, w_hit, w_ovf, w_accept, w_clrDone;

  assign w_nibble  = (r_state == LOOK_HI || r_state == EVAL_HI) ?
                     r_byte[2*SYM_W-1:SYM_W] : r_byte[SYM_W-1:0];
  assign w_isEval  = (r_state == EVAL_HI) || (r_state == EVAL_LO);
  assign w_miss    = (G_RDATA == '0);
  // next_free only reaches 2**STATE_W when every state number is taken
  assign w_full    = r_nextFree[STATE_W];
  assign w_alloc   = w_isEval && w_miss && !w_full && !CLEAR;
  assign w_ovf     = w_isEval && w_miss && w_full && !CLEAR;
  assign w_hit     = w_isEval && !w_miss && !CLEAR;
  assign w_accept  = (r_state == IDLE) && KEY_VALID && !CLEAR;
  assign w_clrDone = (r_state == CLR) && !CLEAR && (r_clrCnt == '1);

  assign KEY_READY  = (r_state == IDLE);
  assign BUSY       = (r_state != IDLE) && (r_state != ERR);
  assign OVERFLOW   = r_overflow;
  assign NUM_STATES = r_nextFree;

  always_comb begin
    w_nextState = r_state;
    G_RADDR     = '0;
    G_WE        = 1'b0;
    G_WADDR     = '0;
    G_WDATA     = '0;
    M_WE        = 1'b0;
    M_WADDR     = '0;
    M_WDATA     = 1'b0;
    case (r_state)
      IDLE:    if (KEY_VALID) w_nextState = LOOK_HI;
      LOOK_HI: begin
        G_RADDR     = {r_cur, w_nibble};
        w_nextState = EVAL_HI;
      end
      EVAL_HI: w_nextState = w_ovf ? ERR : LOOK_LO;
      LOOK_LO: begin
        G_RADDR     = {r_cur, w_nibble};
        w_nextState = EVAL_LO;
      end
      EVAL_LO: begin
        if (w_ovf)       w_nextState = ERR;
        else if (r_last) w_nextState = MARK;
        else             w_nextState = IDLE;
      end
      MARK: begin
        M_WE        = !CLEAR;
        M_WADDR     = CLEAR ? '0 : r_cur;
        M_WDATA     = !CLEAR;
        w_nextState = IDLE;
      end
      CLR: begin
        G_WE    = 1'b1;
        G_WADDR = r_clrCnt;
        // the match-flag RAM only spans the first 2**STATE_W counter values
        if (r_clrCnt[ADDR_W-1:STATE_W] == '0) begin
          M_WE    = 1'b1;
          M_WADDR = r_clrCnt[STATE_W-1:0];
        end
        if (r_clrCnt == '1) w_nextState = IDLE;
      end
      ERR: w_nextState = ERR;
    endcase
    if (w_alloc) begin
      G_WE    = 1'b1;
      G_WADDR = {r_cur, w_nibble};
      G_WDATA = r_nextFree[STATE_W-1:0];
    end
    if (CLEAR) w_nextState = CLR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_cur      <= '0;
      r_nextFree <= (STATE_W+1)'(1);
      r_overflow <= 1'b0;
      r_clrCnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (CLEAR)               r_clrCnt <= '0;
      else if (r_state == CLR) r_clrCnt <= r_clrCnt + ADDR_W'(1);
      if (w_accept) begin
        r_byte <= KEY_DATA;
        r_last <= KEY_LAST;
      end
      if (w_alloc) begin
        r_cur      <= r_nextFree[STATE_W-1:0];
        r_nextFree <= r_nextFree + (STATE_W+1)'(1);
      end else if (w_hit) begin
        r_cur <= G_RDATA;
      end else if (w_clrDone) begin
        r_cur      <= '0;
        r_nextFree <= (STATE_W+1)'(1);
      end else if (r_state == MARK) begin
        r_cur <= '0;
      end
      if (w_ovf)          r_overflow <= 1'b1;
      else if (w_clrDone) r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trie_table_writer.sv
// Bench for trie_table_writer: goto/match RAMs, a keyword-level trie model that
// schedules expected per-cycle outputs, and directed plus random keyword traffic.
module tb_trie_table_writer;

  logic        CLK = 1'b0;
  logic        RST, CLEAR, KEY_VALID, KEY_LAST;
  logic [7:0]  KEY_DATA;
  logic        KEY_READY;
  logic [11:0] G_RADDR, G_WADDR;
  logic [7:0]  G_RDATA, G_WDATA, M_WADDR;
  logic        G_WE, M_WE, M_WDATA, BUSY, OVERFLOW;
  logic [8:0]  NUM_STATES;

  int assertions = 0;
  int failures   = 0;

  trie_table_writer dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR),
    .KEY_VALID(KEY_VALID), .KEY_READY(KEY_READY), .KEY_DATA(KEY_DATA), .KEY_LAST(KEY_LAST),
    .G_RADDR(G_RADDR), .G_RDATA(G_RDATA), .G_WE(G_WE), .G_WADDR(G_WADDR), .G_WDATA(G_WDATA),
    .M_WE(M_WE), .M_WADDR(M_WADDR), .M_WDATA(M_WDATA),
    .BUSY(BUSY), .OVERFLOW(OVERFLOW), .NUM_STATES(NUM_STATES)
  );

  always #5 CLK = ~CLK;

  // Goto RAM with synchronous read, plus the match-flag RAM
  logic [7:0] gMem [4096];
  logic       mMem [256];
  always @(posedge CLK) begin
    G_RDATA <= gMem[G_RADDR];
    if (G_WE) gMem[G_WADDR] <= G_WDATA;
    if (M_WE) mMem[M_WADDR] <= M_WDATA;
  end

  int gweCnt = 0, mweCnt = 0, busyCnt = 0, krLowCnt = 0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (G_WE) gweCnt++;
      if (M_WE) mweCnt++;
      if (BUSY) busyCnt++;
      if (!KEY_READY) krLowCnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    assertions++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Expected outputs for one cycle
  typedef struct packed {
    logic        kr, busy;
    logic [11:0] raddr;
    logic        gwe;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic        mwe;
    logic [7:0]  maddr;
    logic        mdata, ovf;
    logic [8:0]  ns;
    logic        isClr, clrEnd;
  } exp_t;

  exp_t expQ[$];
  int   trie[int];
  int   mCur = 0, mNf = 1;
  bit   mOvf = 0, mErr = 0;

  function automatic exp_t blankExp(input logic [8:0] ns, input logic ov);
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    e.ns   = ns;
    e.ovf  = ov;
    return e;
  endfunction

  // Walks one byte through the trie, queuing the per-cycle outputs it implies
  task automatic modelByte(input logic [7:0] b, input logic last);
    exp_t e;
    int nib, key;
    for (int k = 0; k < 2; k++) begin
      nib = (k == 0) ? int'(b[7:4]) : int'(b[3:0]);
      key = mCur * 16 + nib;
      e = blankExp(9'(mNf), 1'b0);
      e.raddr = 12'(key);
      expQ.push_back(e);
      e = blankExp(9'(mNf), 1'b0);
      if (trie.exists(key)) begin
        mCur = trie[key];
      end else if (mNf < 256) begin
        e.gwe = 1'b1; e.waddr = 12'(key); e.wdata = 8'(mNf);
        trie[key] = mNf;
        mCur = mNf;
        mNf++;
      end else begin
        expQ.push_back(e);
        mOvf = 1'b1;
        mErr = 1'b1;
        return;
      end
      expQ.push_back(e);
    end
    if (last) begin
      e = blankExp(9'(mNf), 1'b0);
      e.mwe = 1'b1; e.maddr = 8'(mCur); e.mdata = 1'b1;
      expQ.push_back(e);
      mCur = 0;
    end
  endtask

  exp_t        modelE;
  logic [8:0]  clrNs;
  logic        clrOv;
  bit          wasIdle;

  // Advances the model at every edge: clears, consumed cycles, new handshakes
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      expQ.delete();
      mCur = 0; mNf = 1; mOvf = 1'b0; mErr = 1'b0;
    end else if (CLEAR) begin
      if (expQ.size() > 0) begin
        clrNs = expQ[0].ns; clrOv = expQ[0].ovf;
      end else begin
        clrNs = 9'(mNf); clrOv = mOvf;
      end
      expQ.delete();
      trie.delete();
      mCur = 0;
      for (int c = 0; c < 4096; c++) begin
        modelE = blankExp(clrNs, clrOv);
        modelE.isClr = 1'b1; modelE.gwe = 1'b1; modelE.waddr = 12'(c);
        if (c < 256) begin
          modelE.mwe = 1'b1; modelE.maddr = 8'(c);
        end
        modelE.clrEnd = (c == 4095);
        expQ.push_back(modelE);
      end
    end else begin
      wasIdle = (expQ.size() == 0);
      if (!wasIdle) begin
        modelE = expQ.pop_front();
        if (modelE.clrEnd) begin
          mNf = 1; mOvf = 1'b0; mErr = 1'b0; mCur = 0;
        end
      end else if (!mErr && KEY_VALID) begin
        modelByte(KEY_DATA, KEY_LAST);
      end
    end
  end

  exp_t        cmpE;
  logic [54:0] actVec, reqVec;
  always @(negedge CLK) begin
    if (!RST) begin
      if (expQ.size() > 0) begin
        cmpE = expQ[0];
      end else begin
        cmpE = '0;
        cmpE.kr  = !mErr;
        cmpE.ns  = 9'(mNf);
        cmpE.ovf = mOvf;
      end
      if (CLEAR && !cmpE.isClr) begin
        cmpE.gwe = 1'b0; cmpE.waddr = '0; cmpE.wdata = '0;
        cmpE.mwe = 1'b0; cmpE.maddr = '0; cmpE.mdata = 1'b0;
      end
      actVec = {KEY_READY, BUSY, G_RADDR, G_WE, G_WADDR, G_WDATA, M_WE, M_WADDR, M_WDATA, OVERFLOW, NUM_STATES};
      reqVec = {cmpE.kr, cmpE.busy, cmpE.raddr, cmpE.gwe, cmpE.waddr, cmpE.wdata,
                cmpE.mwe, cmpE.maddr, cmpE.mdata, cmpE.ovf, cmpE.ns};
      checkOutput("cycle outputs", 64'(actVec), 64'(reqVec));
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic last);
    bit done = 0;
    int guard = 0;
    KEY_VALID = 1'b1; KEY_DATA = b; KEY_LAST = last;
    while (!done && guard < 10000) begin
      @(negedge CLK);
      if (KEY_READY && !CLEAR) begin
        @(posedge CLK); #1;
        done = 1;
      end
      guard++;
    end
    KEY_VALID = 1'b0;
    if (!done) checkOutput("handshake timeout", 64'(0), 64'(1));
  endtask

  task automatic doClear();
    @(posedge CLK); #1 CLEAR = 1'b1;
    @(posedge CLK); #1 CLEAR = 1'b0;
    repeat (4100) @(posedge CLK);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int g0, m0, b0, k0, guard, len, waitCnt;
  bit got;

  initial begin
    RST = 1'b1; CLEAR = 1'b0; KEY_VALID = 1'b0; KEY_DATA = '0; KEY_LAST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset KEY_READY", 64'(KEY_READY), 64'(1));
    checkOutput("reset BUSY", 64'(BUSY), 64'(0));
    checkOutput("reset NUM_STATES", 64'(NUM_STATES), 64'(1));
    checkOutput("reset OVERFLOW", 64'(OVERFLOW), 64'(0));
    checkOutput("reset write ports", 64'({G_WE, M_WE, G_WADDR, G_WDATA, M_WADDR, M_WDATA, G_RADDR}), 64'(0));
    RST = 1'b0;

    $display("[TB] initial clear");
    g0 = gweCnt; m0 = mweCnt; b0 = busyCnt;
    doClear();
    checkOutput("clear G_WE pulses", 64'(gweCnt - g0), 64'(4096));
    checkOutput("clear M_WE pulses", 64'(mweCnt - m0), 64'(256));
    checkOutput("clear BUSY cycles", 64'(busyCnt - b0), 64'(4096));
    checkOutput("clear NUM_STATES", 64'(NUM_STATES), 64'(1));

    $display("[TB] keyword 0x41");
    k0 = krLowCnt;
    applyStimulus(8'h41, 1'b1);
    idleCycles(8);
    checkOutput("0x41 ready-low cycles", 64'(krLowCnt - k0), 64'(5));
    checkOutput("goto {0,4}", 64'(gMem[12'h004]), 64'(1));
    checkOutput("goto {1,1}", 64'(gMem[12'h011]), 64'(2));
    checkOutput("match state 2", 64'(mMem[2]), 64'(1));
    checkOutput("0x41 NUM_STATES", 64'(NUM_STATES), 64'(3));

    $display("[TB] keyword 0x42");
    g0 = gweCnt;
    applyStimulus(8'h42, 1'b1);
    idleCycles(8);
    checkOutput("0x42 goto writes", 64'(gweCnt - g0), 64'(1));
    checkOutput("goto {1,2}", 64'(gMem[12'h012]), 64'(3));
    checkOutput("match state 3", 64'(mMem[3]), 64'(1));
    checkOutput("0x42 NUM_STATES", 64'(NUM_STATES), 64'(4));

    $display("[TB] keyword 0x41 0x41");
    k0 = krLowCnt;
    applyStimulus(8'h41, 1'b0);
    idleCycles(6);
    checkOutput("first byte ready-low cycles", 64'(krLowCnt - k0), 64'(4));
    applyStimulus(8'h41, 1'b1);
    idleCycles(8);
    checkOutput("goto {2,4}", 64'(gMem[12'h024]), 64'(4));
    checkOutput("goto {4,1}", 64'(gMem[12'h041]), 64'(5));
    checkOutput("match state 5", 64'(mMem[5]), 64'(1));
    checkOutput("match state 4", 64'(mMem[4]), 64'(0));
    checkOutput("two-byte NUM_STATES", 64'(NUM_STATES), 64'(6));

    $display("[TB] duplicate keyword 0x41");
    g0 = gweCnt; m0 = mweCnt;
    applyStimulus(8'h41, 1'b1);
    idleCycles(8);
    checkOutput("duplicate goto writes", 64'(gweCnt - g0), 64'(0));
    checkOutput("duplicate match writes", 64'(mweCnt - m0), 64'(1));
    checkOutput("duplicate NUM_STATES", 64'(NUM_STATES), 64'(6));

    $display("[TB] reset mid-keyword");
    applyStimulus(8'h77, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    checkOutput("mid reset KEY_READY", 64'(KEY_READY), 64'(1));
    checkOutput("mid reset G_WE", 64'(G_WE), 64'(0));
    checkOutput("mid reset BUSY", 64'(BUSY), 64'(0));
    checkOutput("mid reset NUM_STATES", 64'(NUM_STATES), 64'(1));
    checkOutput("mid reset G_RADDR", 64'(G_RADDR), 64'(0));
    @(posedge CLK); #1 RST = 1'b0;
    doClear();

    $display("[TB] random keywords until overflow");
    guard = 0;
    while (!mErr && guard < 3000) begin
      len = $urandom_range(1, 3);
      for (int i = 0; i < len && !mErr; i++) applyStimulus(8'($urandom), (i == len - 1));
      guard++;
    end
    checkOutput("overflow reached by model", 64'(mErr), 64'(1));
    idleCycles(8);
    checkOutput("overflow flag", 64'(OVERFLOW), 64'(1));
    checkOutput("overflow KEY_READY", 64'(KEY_READY), 64'(0));
    checkOutput("overflow BUSY", 64'(BUSY), 64'(0));
    checkOutput("overflow NUM_STATES", 64'(NUM_STATES), 64'(256));
    doClear();
    checkOutput("post-clear OVERFLOW", 64'(OVERFLOW), 64'(0));
    checkOutput("post-clear NUM_STATES", 64'(NUM_STATES), 64'(1));
    checkOutput("post-clear KEY_READY", 64'(KEY_READY), 64'(1));

    $display("[TB] clear during EVAL_LO with a held byte");
    KEY_VALID = 1'b1; KEY_DATA = 8'h5A; KEY_LAST = 1'b1;
    got = 0; waitCnt = 0;
    while (!got && waitCnt < 100) begin
      @(negedge CLK);
      if (KEY_READY) begin
        @(posedge CLK); #1;
        got = 1;
      end
      waitCnt++;
    end
    checkOutput("first handshake seen", 64'(got), 64'(1));
    KEY_DATA = 8'hC3;
    repeat (3) @(posedge CLK);
    #1 CLEAR = 1'b1;
    #3;
    checkOutput("EVAL_LO under clear G_WE", 64'(G_WE), 64'(0));
    checkOutput("EVAL_LO under clear KEY_READY", 64'(KEY_READY), 64'(0));
    @(posedge CLK); #1 CLEAR = 1'b0;
    checkOutput("CLR entered", 64'({BUSY, G_WE, M_WE, G_WADDR}), 64'({1'b1, 1'b1, 1'b1, 12'h000}));
    got = 0; waitCnt = 0;
    while (!got && waitCnt < 5000) begin
      @(negedge CLK);
      if (KEY_READY) begin
        @(posedge CLK); #1;
        got = 1;
      end
      waitCnt++;
    end
    KEY_VALID = 1'b0;
    checkOutput("held byte accepted", 64'(got), 64'(1));
    idleCycles(8);
    checkOutput("held byte NUM_STATES", 64'(NUM_STATES), 64'(3));
    checkOutput("held goto {0,C}", 64'(gMem[12'h00C]), 64'(1));
    checkOutput("held goto {1,3}", 64'(gMem[12'h013]), 64'(2));
    checkOutput("held match state 2", 64'(mMem[2]), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/trie_table_writer.md
Name: trie_table_writer

Overview:
- Builds the goto table that the run-time matcher walks during search. Also sets the per-state match flags.
- Accepts keyword bytes over a valid/ready stream and walks the trie already in the goto RAM. Allocates a new state whenever a transition is missing, then writes the new goto entry.
- Sits between the host loader and the write ports of the goto RAM and the match-flag RAM. The failure table is computed by a separate block after DONE.

Parameters:
- STATE_W, 8, state number width; state 0 is root; goto entry value 0 means "no transition".
- SYM_W, 4, symbol width; each keyword byte is two symbols, high nibble first.
- ADDR_W, 12, goto RAM address width = STATE_W + SYM_W; address = {state, symbol}.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- CLEAR  in  1  one-cycle pulse: zero both tables and restart allocation
- KEY_VALID  in  1  keyword byte valid
- KEY_READY  out  1  byte accepted when KEY_VALID & KEY_READY at a CLK edge
- KEY_DATA  in  8  keyword byte
- KEY_LAST  in  1  byte is the final byte of the keyword
- G_RADDR  out  12  goto RAM read address; RAM has synchronous read, data valid the cycle after
- G_RDATA  in  8  goto RAM read data
- G_WE  out  1  goto RAM write enable
- G_WADDR  out  12  goto RAM write address
- G_WDATA  out  8  goto RAM write data
- M_WE  out  1  match-flag RAM write enable
- M_WADDR  out  8  match-flag RAM address (state)
- M_WDATA  out  1  match flag value
- BUSY  out  1  high in any state other than IDLE and ERR
- OVERFLOW  out  1  sticky; state space exhausted
- NUM_STATES  out  9  states in use, including root

Behaviour:
- Reset values:
  - FSM = IDLE; cur = 0; next_free = 1; NUM_STATES = 1.
  - KEY_READY = 1 (it equals FSM==IDLE).
  - G_WE = 0, M_WE = 0, all addresses/data = 0, BUSY = 0, OVERFLOW = 0.
- FSM states: IDLE, LOOK_HI, EVAL_HI, LOOK_LO, EVAL_LO, MARK, CLR, ERR.
- IDLE:
  - On handshake, latch KEY_DATA and KEY_LAST, then go to LOOK_HI.
- LOOK_x:
  - Drive G_RADDR = {cur, nibble}, then go to EVAL_x.
- EVAL_x: sample G_RDATA.
  - Nonzero: cur <= G_RDATA, no write.
  - Zero and next_free < 256: G_WE = 1 for this cycle only, G_WADDR = {cur, nibble}, G_WDATA = next_free. Then cur <= next_free, next_free++, NUM_STATES++.
  - Zero and next_free == 256: OVERFLOW <= 1 and go to ERR. The byte is discarded and no write occurs.
  - From EVAL_HI, continue to LOOK_LO.
  - From EVAL_LO: go to MARK if the latched LAST is set, otherwise to IDLE.
- MARK:
  - M_WE = 1, M_WADDR = cur, M_WDATA = 1.
  - cur <= 0, then go to IDLE.
- Latency:
  - Non-last byte: 4 cycles from handshake to KEY_READY high again.
  - Last byte: 5 cycles.
  - Throughput is one byte per 4 or 5 cycles.
- Keyword state:
  - A keyword spans bytes until KEY_LAST; cur persists across bytes of the same keyword.
  - A duplicate keyword allocates nothing and re-marks the same state.
- ERR:
  - KEY_READY = 0, BUSY = 0.
  - Left only via CLEAR or RST.
- CLEAR (from any state, including mid-keyword):
  - Priority over a simultaneous handshake; that byte is not accepted.
  - Aborts the keyword in progress and enters CLR with a 12-bit counter at 0.
  - CLR writes G_WE = 1, G_WDATA = 0 at every address 0..4095, one per cycle.
  - During counter values 0..255 it also writes M_WE = 1, M_WADDR = counter[7:0], M_WDATA = 0.
  - Wrap of the counter after 4095 ends the clear: 4096 cycles total.
  - On exit, return to IDLE with cur = 0, next_free = 1, NUM_STATES = 1, OVERFLOW = 0.
  - CLEAR pulses received during CLR restart the counter at 0.
- Write hazard: a goto write in EVAL is never followed by a read of the same address in the next cycle. The trie path only moves forward to the new state, whose entries are all zero.
- Root: root (state 0) is never an allocation target, so 0 stays unambiguous as "miss".
- RST assertion mid-operation: outputs return to reset values immediately. The tables are not cleared by RST.

Test Plan:
- RST, then CLEAR → 4096 G_WE pulses with G_WDATA = 0 and 256 M_WE pulses with M_WDATA = 0; BUSY high for exactly 4096 cycles; NUM_STATES = 1.
- Keyword 0x41 (LAST), RAM model returns 0 on all reads → writes {0,4}=1 and {1,1}=2; M_WE at state 2; NUM_STATES = 3; KEY_READY low for 5 cycles.
- Then keyword 0x42 (LAST) → hit on {0,4}=1 with no write; writes {1,2}=3; marks state 3; NUM_STATES = 4.
- Two-byte keyword 0x41,0x41 (LAST on the second byte) after the above → two hits then allocation of 4 and 5; only state 5 marked; KEY_READY high again 4 cycles after the first byte.
- Feed distinct keywords until next_free == 256, then one more miss → OVERFLOW = 1, no G_WE on that miss, KEY_READY held 0; CLEAR → OVERFLOW = 0 and NUM_STATES = 1 after 4096 cycles.
- CLEAR asserted in EVAL_LO with KEY_VALID held high → no MARK write, no handshake that cycle, CLR entered next cycle; after the clear, the held byte is accepted.
